// File: rtl/alu_exec_stage_if.sv
// Handshake and data bundle between the ALU decode side, the execute stage
// and the downstream writeback/memory consumer.
interface alu_exec_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [4:0]       RD_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic [4:0]       RD_out;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, RD_in, out_ready,
        input  in_ready, out_valid, Result, Zero, Negative, Carry, Overflow, RD_out
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, RD_in, out_ready,
        output in_ready, out_valid, Result, Zero, Negative, Carry, Overflow, RD_out
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: computes result/flags and holds them in a
// 2-entry output FIFO with valid/ready handshakes on both sides.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    alu_exec_stage_if.slave   bus
);
    localparam int unsigned MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
        logic [4:0]       rd;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    occ_e   occ_q, occ_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;

    logic       in_ready_w, out_valid_w, push_w, pop_w;
    logic [WIDTH:0] sum_w, diff_w;
    logic       ovf_add_w, ovf_sub_w;
    entry_t     alu_ent;

    always_comb begin
        sum_w     = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
        diff_w    = {1'b0, bus.SrcA} - {1'b0, bus.SrcB};
        ovf_add_w = (bus.SrcA[MSB] == bus.SrcB[MSB]) & (sum_w[MSB] != bus.SrcA[MSB]);
        ovf_sub_w = (bus.SrcA[MSB] != bus.SrcB[MSB]) & (diff_w[MSB] != bus.SrcA[MSB]);
        alu_ent    = '0;
        alu_ent.rd = bus.RD_in;
        case (bus.ALUControl)
            3'b000: begin
                alu_ent.result = sum_w[MSB:0];
                alu_ent.carry  = sum_w[WIDTH];
                alu_ent.ovf    = ovf_add_w;
            end
            3'b001: begin
                alu_ent.result = diff_w[MSB:0];
                alu_ent.carry  = ~diff_w[WIDTH];
                alu_ent.ovf    = ovf_sub_w;
            end
            3'b010:  alu_ent.result = bus.SrcA & bus.SrcB;
            3'b011:  alu_ent.result = bus.SrcA | bus.SrcB;
            3'b101:  alu_ent.result = {{(WIDTH-1){1'b0}}, diff_w[MSB] ^ ovf_sub_w};
            default: alu_ent.result = '0;
        endcase
        alu_ent.zero = (alu_ent.result == '0);
        alu_ent.neg  = alu_ent.result[MSB];
    end

    assign push_w = bus.in_valid & in_ready_w;
    assign pop_w  = out_valid_w & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: if (push_w) occ_d = OCC_ONE;
                OCC_ONE: begin
                    if (pop_w && !push_w)      occ_d = OCC_EMPTY;
                    else if (push_w && !pop_w) occ_d = OCC_FULL;
                end
                OCC_FULL:  if (pop_w) occ_d = OCC_ONE;
                default:   occ_d = OCC_EMPTY;
            endcase
        end
    end

    // Simultaneous push and pop only happens with one entry: the new op becomes the head.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (!flush) begin
            if (pop_w) head_d = tail_q;
            if (push_w) begin
                if (occ_q == OCC_EMPTY || (occ_q == OCC_ONE && pop_w)) head_d = alu_ent;
                else                                                   tail_d = alu_ent;
            end
        end
    end

    always_comb begin
        in_ready_w   = rst & (occ_q != OCC_FULL);
        out_valid_w  = rst & (occ_q != OCC_EMPTY);
        bus.in_ready  = in_ready_w;
        bus.out_valid = out_valid_w;
        bus.Result    = '0;
        bus.Zero      = 1'b0;
        bus.Negative  = 1'b0;
        bus.Carry     = 1'b0;
        bus.Overflow  = 1'b0;
        bus.RD_out    = '0;
        if (out_valid_w) begin
            bus.Result   = head_q.result;
            bus.Zero     = head_q.zero;
            bus.Negative = head_q.neg;
            bus.Carry    = head_q.carry;
            bus.Overflow = head_q.ovf;
            bus.RD_out   = head_q.rd;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized self-checking bench for alu_exec_stage against a queue-based
// reference model using plain wide arithmetic.
module tb_alu_exec_stage;
    localparam int unsigned WIDTH = 32;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(WIDTH)) bus();

    alu_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        bit [31:0] res;
        bit [3:0]  flags;   // {Zero, Negative, Carry, Overflow}
        bit [4:0]  rd;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t alu_ref(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                                     input bit [4:0] rd);
        ent_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        bit     c = 0;
        bit     v = 0;
        case (op)
            3'd0: begin
                r = ua + ub;
                c = (r >= 64'sd4294967296);
                v = ((sa + sb) > 64'sd2147483647) || ((sa + sb) < -64'sd2147483648);
            end
            3'd1: begin
                r = ua - ub;
                c = (ua >= ub);
                v = ((sa - sb) > 64'sd2147483647) || ((sa - sb) < -64'sd2147483648);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd5: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        e.res   = r[31:0];
        e.flags = {e.res == 0, e.res[31], c, v};
        e.rd    = rd;
        return e;
    endfunction

    task automatic verify();
        ent_t h;
        bit   has = (exp_q.size() > 0);
        check_eq("in_ready", bus.in_ready, rst && exp_q.size() < 2);
        check_eq("out_valid", bus.out_valid, has);
        if (has) h = exp_q[0];
        else begin
            h.res = 0; h.flags = 0; h.rd = 0;
        end
        check_eq("result", bus.Result, h.res);
        check_eq("flags", {bus.Zero, bus.Negative, bus.Carry, bus.Overflow}, h.flags);
        check_eq("rd_out", bus.RD_out, h.rd);
    endtask

    // One clock: drive, update the model at the edge, check at the following negedge.
    task automatic step(input bit iv, input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                        input bit [4:0] rd, input bit ordy, input bit fl, input bit rv);
        bit   m_ready, m_valid;
        ent_t e;
        rst            = rv;
        flush          = fl;
        bus.in_valid   = iv;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.RD_in      = rd;
        bus.out_ready  = ordy;
        m_ready = rv && exp_q.size() < 2;
        m_valid = rv && exp_q.size() > 0;
        e = alu_ref(op, a, b, rd);
        @(posedge clk);
        if (!rv || fl) exp_q.delete();
        else begin
            if (m_valid && ordy) void'(exp_q.pop_front());
            if (iv && m_ready) exp_q.push_back(e);
        end
        @(negedge clk);
        verify();
    endtask

    task automatic idle(input bit ordy);
        step(0, 3'd0, 0, 0, 0, ordy, 0, 1);
    endtask

    function automatic bit [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.in_valid   = 0;
        bus.ALUControl = 0;
        bus.SrcA       = 0;
        bus.SrcB       = 0;
        bus.RD_in      = 0;
        bus.out_ready  = 0;

        step(0, 3'd0, 0, 0, 0, 1, 0, 0);
        step(1, 3'd0, 1, 2, 3, 1, 0, 0);
        idle(1);

        step(1, 3'd0, 32'h7FFF_FFFF, 32'h1, 5'd5, 1, 0, 1);
        check_eq("tp_add_result", bus.Result, 32'h8000_0000);
        check_eq("tp_add_flags", {bus.Zero, bus.Negative, bus.Carry, bus.Overflow}, 4'b0101);
        step(1, 3'd1, 5, 5, 1, 1, 0, 1);
        check_eq("tp_sub_zero", {bus.Zero, bus.Carry}, 2'b11);
        step(1, 3'd1, 0, 1, 2, 1, 0, 1);
        check_eq("tp_sub_neg", bus.Result, 32'hFFFF_FFFF);
        step(1, 3'd5, 32'hFFFF_FFFF, 1, 3, 1, 0, 1);
        check_eq("tp_slt_true", bus.Result, 32'h1);
        step(1, 3'd5, 1, 32'hFFFF_FFFF, 4, 1, 0, 1);
        step(1, 3'd6, 32'h1234, 32'h5678, 6, 1, 0, 1);
        check_eq("tp_undef_zero", bus.Zero, 1'b1);
        idle(1);

        step(1, 3'd2, 32'hF0F0, 32'hFF00, 7, 0, 0, 1);
        step(1, 3'd3, 32'h0F, 32'hF0, 8, 0, 0, 1);
        check_eq("tp_full_ready", bus.in_ready, 1'b0);
        step(1, 3'd0, 9, 9, 9, 0, 0, 1);
        idle(1);
        check_eq("tp_pop_order", bus.Result, 32'hFF);
        idle(1);

        step(1, 3'd0, 1, 1, 1, 0, 0, 1);
        step(1, 3'd0, 2, 2, 2, 0, 0, 1);
        step(1, 3'd0, 3, 3, 3, 1, 1, 1);
        check_eq("tp_flush_empty", bus.out_valid, 1'b0);
        step(1, 3'd0, 4, 4, 4, 0, 0, 1);
        step(1, 3'd0, 5, 5, 5, 0, 0, 1);
        step(1, 3'd0, 6, 6, 6, 1, 0, 0);
        idle(0);

        for (int i = 0; i < 3000; i++) begin
            bit [2:0] op = 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, op, rand_operand(), rand_operand(),
                 5'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
